// File: rtl/spi_fetch_master_if.sv
// ---------------------------------------------------------------------------
// spi_fetch_master_if
//   CPU fetch-side handshake between the instruction fetch stage and the
//   SPI flash fetch master.
//
//   fetch_req    CPU -> master  request a fetch (looked at only while idle)
//   fetch_addr   CPU -> master  16-bit instruction word address
//   instr        master -> CPU  last fetched instruction word
//   instr_valid  master -> CPU  one-cycle pulse when instr is updated
//   busy         master -> CPU  transaction in progress
//
//   modport master : the CPU fetch stage (issues requests)
//   modport slave  : the SPI fetch engine (serves requests)
// ---------------------------------------------------------------------------
interface spi_fetch_master_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic        busy;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  instr,
        input  instr_valid,
        input  busy
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output instr,
        output instr_valid,
        output busy
    );
endinterface

// File: rtl/spi_fetch_master.sv
// ---------------------------------------------------------------------------
// spi_fetch_master
//   Fetches one 16-bit instruction per request from SPI flash with a READ
//   transaction: 8 command bits, 24 byte-address bits, 16 data bits, SPI
//   mode 0, MSB first. Accept-to-instr_valid latency is 96*CLK_DIV cycles.
//
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   fetch       CPU fetch handshake (slave side of spi_fetch_master_if)
//   spi_cs      chip select, active low
//   spi_sck     SPI clock, idles low
//   spi_mosi    serial data out
//   spi_miso    serial data in, sampled on SCK rise
//   spi_state   phase: 0=IDLE 1=CMD 2=ADDR 3=DATA
//   bit_cnt     bit index within the current phase
//   pc_current  latched word address of the current/last fetch
// ---------------------------------------------------------------------------
module spi_fetch_master #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic               clk,
    input  logic               rst,
    spi_fetch_master_if.slave  fetch,
    output logic               spi_cs,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic [1:0]         spi_state,
    output logic [4:0]         bit_cnt,
    output logic [15:0]        pc_current
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_e            state_q, state_d;
    logic [4:0]        cnt_q,   cnt_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic              sck_q,   sck_d;
    logic              cs_q,    cs_d;
    logic              mosi_q,  mosi_d;
    logic              busy_q,  busy_d;
    logic              valid_q, valid_d;
    logic [15:0]       pc_q,    pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [31:0]       tx_q,    tx_d;   // bits still to be shifted out
    logic [15:0]       rx_q,    rx_d;   // instruction being assembled
    logic              tick;

    // SCK toggles whenever the divider wraps during a transaction.
    assign tick = busy_q && (div_q == DIV_LAST);

    // NOTE: every next-state signal gets a default first, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        pc_d    = pc_q;
        instr_d = instr_q;
        tx_d    = tx_q;
        rx_d    = rx_q;

        if (!busy_q) begin
            div_d = '0;
            if (fetch.fetch_req && state_q == ST_IDLE) begin
                pc_d    = fetch.fetch_addr;
                cs_d    = 1'b0;
                busy_d  = 1'b1;
                state_d = ST_CMD;
                cnt_d   = 5'd0;
                // First bit goes out now; the rest is held pre-shifted.
                mosi_d  = READ_CMD[7];
                tx_d    = {READ_CMD[6:0], 7'b0, fetch.fetch_addr, 1'b0, 1'b0};
            end
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                sck_d = ~sck_q;
                if (!sck_q) begin
                    // Rising SCK: sample MISO, then advance to the index of the
                    // next bit so the flash sees it before the coming fall.
                    if (state_q == ST_DATA) begin
                        rx_d = {rx_q[14:0], spi_miso};
                    end
                    unique case (state_q)
                        ST_CMD: begin
                            if (cnt_q == 5'd7) begin
                                state_d = ST_ADDR;
                                cnt_d   = 5'd0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        ST_ADDR: begin
                            if (cnt_q == 5'd23) begin
                                state_d = ST_DATA;
                                cnt_d   = 5'd0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        ST_DATA: begin
                            if (cnt_q == 5'd15) begin
                                state_d = ST_IDLE;
                                cnt_d   = 5'd0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        default: ;
                    endcase
                end else if (state_q == ST_IDLE) begin
                    // Fall of the last data bit: the phase already returned
                    // to IDLE on the preceding rise, so this ends the frame.
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    instr_d = rx_q;
                    valid_d = 1'b1;
                end else begin
                    // Falling SCK: present the next bit. tx_q is empty once
                    // the address is out, which keeps MOSI low during DATA.
                    mosi_d = tx_q[31];
                    tx_d   = {tx_q[30:0], 1'b0};
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            div_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= 16'd0;
            instr_q <= 16'd0;
            tx_q    <= 32'd0;
            rx_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign spi_cs            = cs_q;
    assign spi_sck           = sck_q;
    assign spi_mosi          = mosi_q;
    assign spi_state         = state_q;
    assign bit_cnt           = cnt_q;
    assign pc_current        = pc_q;
    assign fetch.instr       = instr_q;
    assign fetch.instr_valid = valid_q;
    assign fetch.busy        = busy_q;

endmodule

// File: tb/tb_spi_fetch_master.sv
// ---------------------------------------------------------------------------
// tb_spi_fetch_master
//   Two DUT instances (CLK_DIV=2 and CLK_DIV=1), each with a small SPI flash
//   model whose 16-word memory is indexed by pc_current[3:0] and which drives
//   MISO on SCK fall. Expected results come from the memory contents, the
//   READ frame layout and the 96*CLK_DIV latency rule.
// ---------------------------------------------------------------------------
module tb_spi_fetch_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_fetch_master_if f1 ();
    spi_fetch_master_if f2 ();

    logic        cs1, sck1, mosi1, miso1;
    logic        cs2, sck2, mosi2, miso2;
    logic [1:0]  st1, st2;
    logic [4:0]  cnt1, cnt2;
    logic [15:0] pc1, pc2;

    spi_fetch_master dut1 (
        .clk(clk), .rst(rst), .fetch(f1.slave),
        .spi_cs(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1),
        .spi_state(st1), .bit_cnt(cnt1), .pc_current(pc1)
    );

    spi_fetch_master #(.CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .fetch(f2.slave),
        .spi_cs(cs2), .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(miso2),
        .spi_state(st2), .bit_cnt(cnt2), .pc_current(pc2)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [15:0] mem [16];

    function automatic logic [15:0] ref_instr(input logic [15:0] addr);
        return mem[addr[3:0]];
    endfunction

    // READ command in the top byte, byte address (= word address * 2) below.
    function automatic logic [31:0] ref_frame(input logic [15:0] addr);
        return (32'h03 << 24) | (32'(addr) * 2);
    endfunction

    function automatic logic flash_bit(input logic [15:0] pc, input logic [1:0] st,
                                       input logic [4:0] cnt);
        logic [15:0] w;
        w = mem[pc[3:0]];
        if (st != 2'd3 || cnt > 5'd15) return 1'b0;
        return w[15 - int'(cnt)];
    endfunction

    // ---------------- flash models ----------------
    initial begin miso1 = 1'b0; miso2 = 1'b0; end
    always @(negedge sck1) miso1 = flash_bit(pc1, st1, cnt1);
    always @(negedge sck2) miso2 = flash_bit(pc2, st2, cnt2);

    // ---------------- monitors ----------------
    logic [31:0] cap1, cap2;
    int          nb1 = 0, nb2 = 0;
    always @(posedge sck1) if (nb1 < 32) begin cap1[31-nb1] = mosi1; nb1++; end
    always @(posedge sck2) if (nb2 < 32) begin cap2[31-nb2] = mosi2; nb2++; end

    logic [1:0] seq1 [$];
    logic [1:0] prev_st1 = 2'd0;
    int         maxc1 [4];
    int         cs_bad1 = 0;
    int         sck_bad2 = 0;
    logic       prev_sck2 = 1'b0;
    logic       prev_busy2 = 1'b0;

    always @(negedge clk) begin
        if (st1 !== prev_st1) begin
            seq1.push_back(st1);
            prev_st1 = st1;
        end
        if (int'(cnt1) > maxc1[st1]) maxc1[st1] = int'(cnt1);
        if (f1.busy === 1'b1 && cs1 !== 1'b0) cs_bad1++;
        if (f2.busy === 1'b1 && prev_busy2 && sck2 === prev_sck2) sck_bad2++;
        prev_sck2  = sck2;
        prev_busy2 = f2.busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic clear_monitors();
        nb1 = 0; nb2 = 0;
        seq1.delete();
        for (int i = 0; i < 4; i++) maxc1[i] = 0;
        cs_bad1 = 0; sck_bad2 = 0;
    endtask

    // Waits for instr_valid on the selected DUT; lat counts edges from the
    // edge after accept. A missing pulse is counted as a failed check.
    task automatic wait_valid(input int sel, output logic [15:0] got, output int lat);
        logic v;
        lat = 0;
        got = 'x;
        v = 1'b0;
        while (!v && lat < 1000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            v = (sel == 1) ? (f1.instr_valid === 1'b1) : (f2.instr_valid === 1'b1);
        end
        if (v) begin
            got = (sel == 1) ? f1.instr : f2.instr;
        end else begin
            checks++; errors++;
            $display("FAIL timeout: no instr_valid on dut%0d after %0d cycles", sel, lat);
            lat = -1;
        end
    endtask

    // Issues one request, lets it be accepted on the next edge, and waits.
    task automatic do_fetch(input int sel, input logic [15:0] addr,
                            output logic [15:0] got, output int lat,
                            output logic [31:0] frame);
        @(negedge clk);
        clear_monitors();
        if (sel == 1) begin f1.fetch_req = 1'b1; f1.fetch_addr = addr; end
        else          begin f2.fetch_req = 1'b1; f2.fetch_addr = addr; end
        @(posedge clk);
        @(negedge clk);
        f1.fetch_req = 1'b0;
        f2.fetch_req = 1'b0;
        wait_valid(sel, got, lat);
        frame = (sel == 1) ? cap1 : cap2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [42:0] obs, exp;
        exp = {1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 16'd0, 1'b0, 1'b0, 16'd0};
        obs = {cs1, sck1, mosi1, st1, cnt1, f1.instr, f1.instr_valid, f1.busy, pc1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected %h", obs, exp);
        end
        obs = {cs2, sck2, mosi2, st2, cnt2, f2.instr, f2.instr_valid, f2.busy, pc2};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_dut2: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_addr0();
        logic [15:0] got; int lat; logic [31:0] fr;
        do_fetch(1, 16'h0000, got, lat, fr);
        checks++;
        if (got !== 16'h620A) begin errors++; $display("FAIL addr0_instr: got %h expected %h", got, 16'h620A); end
        checks++;
        if (lat != 192) begin errors++; $display("FAIL addr0_latency: got %0d expected 192", lat); end
        checks++;
        if (fr !== ref_frame(16'h0000)) begin errors++; $display("FAIL addr0_mosi: got %h expected %h", fr, ref_frame(16'h0000)); end
    endtask

    task automatic test_phases();
        logic [15:0] got; int lat; logic [31:0] fr; logic [7:0] seq_obs;
        do_fetch(1, 16'h0009, got, lat, fr);
        checks++;
        if (got !== ref_instr(16'h0009)) begin errors++; $display("FAIL addr9_instr: got %h expected %h", got, ref_instr(16'h0009)); end
        seq_obs = 8'hxx;
        if (seq1.size() == 4) seq_obs = {seq1[0], seq1[1], seq1[2], seq1[3]};
        checks++;
        if (seq_obs !== 8'b01_10_11_00) begin errors++; $display("FAIL phase_seq: got %b (%0d entries) expected 01101100", seq_obs, seq1.size()); end
        checks++;
        if (maxc1[1] != 7 || maxc1[2] != 23 || maxc1[3] != 15) begin
            errors++;
            $display("FAIL bitcnt_max: got %0d/%0d/%0d expected 7/23/15", maxc1[1], maxc1[2], maxc1[3]);
        end
        checks++;
        if (cs_bad1 != 0) begin errors++; $display("FAIL cs_low: got %0d busy cycles with cs high, expected 0", cs_bad1); end
    endtask

    task automatic test_addr13();
        logic [15:0] got; int lat; logic [31:0] fr;
        do_fetch(1, 16'h0013, got, lat, fr);
        checks++;
        if (fr[23:0] !== 24'h000026) begin errors++; $display("FAIL addr13_field: got %h expected 000026", fr[23:0]); end
        checks++;
        if (got !== 16'h8600) begin errors++; $display("FAIL addr13_instr: got %h expected 8600", got); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got; int lat;
        @(negedge clk);
        clear_monitors();
        f1.fetch_req = 1'b1; f1.fetch_addr = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        f1.fetch_addr = 16'hBEE3;   // changed while busy: must be ignored
        repeat (50) @(negedge clk);
        checks++;
        if (pc1 !== 16'h0001) begin errors++; $display("FAIL b2b_pc_hold: got %h expected 0001", pc1); end
        f1.fetch_addr = 16'h0002;
        wait_valid(1, got, lat);
        checks++;
        if (got !== ref_instr(16'h0001)) begin errors++; $display("FAIL b2b_first: got %h expected %h", got, ref_instr(16'h0001)); end
        checks++;
        if (cs1 !== 1'b1) begin errors++; $display("FAIL b2b_cs_gap_high: got %b expected 1", cs1); end
        @(negedge clk);
        f1.fetch_req = 1'b0;
        checks++;
        if ({cs1, f1.busy, pc1} !== {1'b0, 1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL b2b_reaccept: got cs=%b busy=%b pc=%h expected cs=0 busy=1 pc=0002", cs1, f1.busy, pc1);
        end
        wait_valid(1, got, lat);
        checks++;
        if (got !== ref_instr(16'h0002)) begin errors++; $display("FAIL b2b_second: got %h expected %h", got, ref_instr(16'h0002)); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got; int lat; logic [31:0] fr; int pulses; logic [42:0] obs, exp;
        @(negedge clk);
        clear_monitors();
        f1.fetch_req = 1'b1; f1.fetch_addr = 16'h000B;
        @(posedge clk);
        @(negedge clk);
        f1.fetch_req = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 16'd0, 1'b0, 1'b0, 16'd0};
        obs = {cs1, sck1, mosi1, st1, cnt1, f1.instr, f1.instr_valid, f1.busy, pc1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL midreset_state: got %h expected %h", obs, exp); end
        pulses = 0;
        repeat (250) begin
            @(negedge clk);
            if (f1.instr_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", pulses); end
        do_fetch(1, 16'h0005, got, lat, fr);
        checks++;
        if (got !== 16'hF700) begin errors++; $display("FAIL midreset_refetch: got %h expected F700", got); end
    endtask

    task automatic test_clkdiv1();
        logic [15:0] got; int lat; logic [31:0] fr;
        do_fetch(2, 16'h0007, got, lat, fr);
        checks++;
        if (got !== 16'h6BFF) begin errors++; $display("FAIL div1_instr: got %h expected 6BFF", got); end
        checks++;
        if (lat != 96) begin errors++; $display("FAIL div1_latency: got %0d expected 96", lat); end
        checks++;
        if (sck_bad2 != 0) begin errors++; $display("FAIL div1_sck_period: got %0d stalled half-periods expected 0", sck_bad2); end
        checks++;
        if (fr !== ref_frame(16'h0007)) begin errors++; $display("FAIL div1_mosi: got %h expected %h", fr, ref_frame(16'h0007)); end
    endtask

    task automatic test_random();
        logic [15:0] addr, got; int lat; logic [31:0] fr;
        for (int i = 0; i < 10; i++) begin
            int sel;
            sel  = (i % 2 == 0) ? 1 : 2;
            addr = 16'($urandom_range(0, 65535));
            do_fetch(sel, addr, got, lat, fr);
            checks++;
            if (got !== ref_instr(addr) || lat != 96 * (sel == 1 ? 2 : 1) || fr !== ref_frame(addr)) begin
                errors++;
                $display("FAIL random_%0d dut%0d addr %h: got instr %h lat %0d frame %h expected %h %0d %h",
                         i, sel, addr, got, lat, fr, ref_instr(addr), 96 * (sel == 1 ? 2 : 1), ref_frame(addr));
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h620A; mem[1] = 16'h6414; mem[2] = 16'h0650; mem[3] = 16'h8600;
        mem[5] = 16'hF700; mem[7] = 16'h6BFF; mem[9] = 16'h9FFF;
        for (int i = 0; i < 4; i++) maxc1[i] = 0;

        rst = 1'b1;
        f1.fetch_req = 1'b0; f1.fetch_addr = 16'h0000;
        f2.fetch_req = 1'b0; f2.fetch_addr = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_addr0();
        test_phases();
        test_addr13();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        test_random();

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
